// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - RV32 load/store funct3 width codes
//   - FSM state encoding used by dmem_responder
//   - alignment helper shared by the lane logic
package dmem_responder_pkg;

    // Load width codes (req_we = 0)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store width codes (req_we = 1)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // funct3[1:0] encodes access size for every legal code (byte/half/word);
    // a halfword must sit on an even address, a word on a multiple of four.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
//   req_*  : valid/ready request channel (we, byte addr, right-aligned wdata, funct3)
//   resp_* : valid/ready response channel (extended load data, error flag)
// master = initiator side, slave = responder side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_lane.sv
// Byte-lane logic for one 32-bit memory word (purely combinational).
//   we       : 1 = store, 0 = load
//   funct3   : RV32 width code
//   addr_lo  : byte offset within the word
//   wdata    : right-aligned store data
//   rword    : current contents of the addressed word
//   byte_en  : lanes to write on a store (zero on format error or load)
//   wword    : store data replicated onto every lane position
//   rdata    : extracted and extended load result (zero on error or store)
//   fmt_err  : illegal funct3 for the direction, or misaligned access
module dmem_lane
    import dmem_responder_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        fmt_err
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [3:0]  be_raw_s;
    logic [31:0] rdata_raw_s;
    logic        bad_code_s;

    // Lane selection, store enables and load extension before error masking
    always_comb begin
        byte_s      = rword[{addr_lo, 3'b000} +: 8];
        half_s      = rword[{addr_lo[1], 4'b0000} +: 16];
        be_raw_s    = 4'b0000;
        wword       = 32'd0;
        rdata_raw_s = 32'd0;
        bad_code_s  = 1'b0;
        if (we) begin
            case (funct3)
                F3_SB: begin
                    be_raw_s = 4'b0001 << addr_lo;
                    wword    = {4{wdata[7:0]}};
                end
                F3_SH: begin
                    be_raw_s = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wword    = {2{wdata[15:0]}};
                end
                F3_SW: begin
                    be_raw_s = 4'b1111;
                    wword    = wdata;
                end
                default: bad_code_s = 1'b1;
            endcase
        end else begin
            case (funct3)
                F3_LB:   rdata_raw_s = {{24{byte_s[7]}}, byte_s};
                F3_LH:   rdata_raw_s = {{16{half_s[15]}}, half_s};
                F3_LW:   rdata_raw_s = rword;
                F3_LBU:  rdata_raw_s = {24'd0, byte_s};
                F3_LHU:  rdata_raw_s = {16'd0, half_s};
                default: bad_code_s  = 1'b1;
            endcase
        end
    end

    assign fmt_err = bad_code_s | f3_misaligned(funct3, addr_lo);
    assign byte_en = fmt_err ? 4'b0000 : be_raw_s;
    assign rdata   = fmt_err ? 32'd0 : rdata_raw_s;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a fixed number of wait states.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : dmem_responder_if.slave request/response channels
// A request is accepted in IDLE, waits WAIT_CYCLES cycles, then commits
// (store writes memory, load captures data) on the edge entering RESP.
// The response is held in RESP until resp_ready. Storage is never reset.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam int         HI_W      = 32'sd30 - AW;
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 32'sd0);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 32'sd1);

    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic        accept_s, commit_s;

    logic        we_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [2:0]  funct3_r;

    logic [31:0] rdata_r;
    logic        err_r;

    logic [31:0] mem_r [DEPTH_WORDS];

    logic        op_we_s;
    logic [31:0] op_addr_s;
    logic [31:0] op_wdata_s;
    logic [2:0]  op_funct3_s;
    logic [AW-1:0] op_idx_s;
    logic        op_oor_s;
    logic        err_s;

    logic [3:0]  lane_be_s;
    logic [31:0] lane_wword_s;
    logic [31:0] lane_rdata_s;
    logic        lane_err_s;

    // With no wait states the commit happens on the accept edge itself, so the
    // operation is taken from the live request; otherwise from the latched copy.
    assign op_we_s     = (state_r == ST_IDLE) ? bus.req_we     : we_r;
    assign op_addr_s   = (state_r == ST_IDLE) ? bus.req_addr   : addr_r;
    assign op_wdata_s  = (state_r == ST_IDLE) ? bus.req_wdata  : wdata_r;
    assign op_funct3_s = (state_r == ST_IDLE) ? bus.req_funct3 : funct3_r;

    assign op_idx_s = op_addr_s[AW+1:2];
    assign op_oor_s = (op_addr_s[31:AW+2] != {HI_W{1'b0}});
    assign err_s    = lane_err_s | op_oor_s;

    dmem_lane u_lane (
        .we      (op_we_s),
        .funct3  (op_funct3_s),
        .addr_lo (op_addr_s[1:0]),
        .wdata   (op_wdata_s),
        .rword   (mem_r[op_idx_s]),
        .byte_en (lane_be_s),
        .wword   (lane_wword_s),
        .rdata   (lane_rdata_s),
        .fmt_err (lane_err_s)
    );

    // Next-state, wait counter and accept/commit strobes
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s = 1'b1;
                    if (NO_WAIT) begin
                        commit_s    = 1'b1;
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = WAIT_INIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                // Return to IDLE only; a new accept needs a separate cycle.
                if (bus.resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Request capture on accept; req_* are ignored outside IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r     <= 1'b0;
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
            funct3_r <= 3'b000;
        end else if (accept_s) begin
            we_r     <= bus.req_we;
            addr_r   <= bus.req_addr;
            wdata_r  <= bus.req_wdata;
            funct3_r <= bus.req_funct3;
        end
    end

    // Response registers: loaded on commit, cleared once the response transfers
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else if (commit_s) begin
            err_r   <= err_s;
            rdata_r <= (err_s || op_we_s) ? 32'd0 : lane_rdata_s;
        end else if ((state_r == ST_RESP) && bus.resp_ready) begin
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end
    end

    // Storage write; reset suppresses a pending commit and never clears contents
    always_ff @(posedge clk) begin
        if (!rst && commit_s && op_we_s && !err_s) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be_s[i]) begin
                    mem_r[op_idx_s][8*i +: 8] <= lane_wword_s[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (state_r == ST_IDLE);
    assign bus.resp_valid = (state_r == ST_RESP);
    assign bus.resp_rdata = rdata_r;
    assign bus.resp_err   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // sel = 0 routes the bench bus to the WAIT_CYCLES=2 DUT, 1 to the WAIT_CYCLES=0 DUT
    logic        sel        = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_we     = 1'b0;
    logic [31:0] req_addr   = 32'd0;
    logic [31:0] req_wdata  = 32'd0;
    logic [2:0]  req_funct3 = 3'b000;
    logic        resp_ready = 1'b0;

    dmem_responder_if if2();
    dmem_responder_if if0();

    assign if2.req_valid  = req_valid & ~sel;
    assign if0.req_valid  = req_valid & sel;
    assign if2.resp_ready = resp_ready & ~sel;
    assign if0.resp_ready = resp_ready & sel;
    assign if2.req_we = req_we;         assign if0.req_we = req_we;
    assign if2.req_addr = req_addr;     assign if0.req_addr = req_addr;
    assign if2.req_wdata = req_wdata;   assign if0.req_wdata = req_wdata;
    assign if2.req_funct3 = req_funct3; assign if0.req_funct3 = req_funct3;

    wire        req_ready_s  = sel ? if0.req_ready  : if2.req_ready;
    wire        resp_valid_s = sel ? if0.resp_valid : if2.resp_valid;
    wire [31:0] resp_rdata_s = sel ? if0.resp_rdata : if2.resp_rdata;
    wire        resp_err_s   = sel ? if0.resp_err   : if2.resp_err;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (.clk(clk), .rst(rst), .bus(if2));
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

    int n_checks = 0;
    int n_fail   = 0;

    // Byte-addressed little-endian model memory, one per DUT (index 0: W=2, 1: W=0)
    logic [7:0] mem_m [2][4096];

    function automatic void model_op(input int d, input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [2:0] f3,
                                     output logic [31:0] rdata, output logic err);
        int size;
        int a;
        logic legal;
        logic [31:0] v;
        size  = 1 << f3[1:0];
        legal = we ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
                   : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        err   = !legal || (addr % size != 0) || (addr >= 32'd4096);
        rdata = 32'd0;
        a     = int'(addr[11:0]);
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mem_m[d][a+i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < size; i++) v = v | ({24'd0, mem_m[d][a+i]} << (8*i));
                if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
                rdata = v;
            end
        end
    endfunction

    // Drives one request, holds resp_ready low for 'hold' cycles once the
    // response appears, and reports data, error and accept-to-valid latency.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat, output bit ok);
        int guard;
        ok = 1'b1; rdata = 32'd0; err = 1'b0; lat = 0; guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        resp_ready = 1'b0;
        while (!req_ready_s && guard < 50) begin @(negedge clk); guard++; end
        if (!req_ready_s) begin ok = 1'b0; req_valid = 1'b0; return; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid_s && lat < 50) begin @(negedge clk); lat++; end
        if (!resp_valid_s) begin ok = 1'b0; return; end
        rdata = resp_rdata_s;
        err   = resp_err_s;
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready_s !== 1'b1 || resp_valid_s !== 1'b0) begin
            n_fail++; $display("FAIL reset_handshake: ready=%b valid=%b required ready=1 valid=0", req_ready_s, resp_valid_s);
        end
        n_checks++;
        if (resp_rdata_s !== 32'd0 || resp_err_s !== 1'b0) begin
            n_fail++; $display("FAIL reset_outputs: rdata=%h err=%b required 0/0", resp_rdata_s, resp_err_s);
        end
        n_checks++;
        if (if0.req_ready !== 1'b1 || if0.resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_w0: ready=%b valid=%b required 1/0", if0.req_ready, if0.resp_valid);
        end
        rst = 1'b0;
    endtask

    // Store known data to every word the later tests touch
    task automatic test_preload(input int d, input int words);
        logic [31:0] rd, w, er; logic e, ee; int lat; bit ok;
        for (int i = 0; i <= words; i++) begin
            logic [31:0] a;
            a = (i == words) ? 32'hFFC : 32'(4*i);
            w = $urandom;
            do_req(1'b1, a, w, F3_SW, 0, rd, e, lat, ok);
            model_op(d, 1'b1, a, w, F3_SW, er, ee);
            n_checks++;
            if (!ok || e !== 1'b0) begin
                n_fail++; $display("FAIL preload: addr=%h ok=%0d err=%b required ok=1 err=0", a, ok, e);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd, er; logic e, ee; int lat; bit ok;
        logic [31:0] exp_rd [9] = '{32'd0, 32'hDEADBEEF, 32'd0, 32'hDEAD7FEF, 32'hFFFFFFDE,
                                    32'h000000DE, 32'h0000DEAD, 32'd0, 32'd0};
        logic        exp_er [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        we_t   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [31:0] ad_t   [9] = '{32'h10, 32'h10, 32'h11, 32'h10, 32'h13, 32'h13, 32'h12, 32'h11, 32'h12};
        logic [31:0] wd_t   [9] = '{32'hDEADBEEF, 32'd0, 32'h7F, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1};
        logic [2:0]  f3_t   [9] = '{F3_SW, F3_LW, F3_SB, F3_LW, F3_LB, F3_LBU, F3_LHU, F3_LH, F3_SW};
        for (int i = 0; i < 9; i++) begin
            do_req(we_t[i], ad_t[i], wd_t[i], f3_t[i], 0, rd, e, lat, ok);
            model_op(0, we_t[i], ad_t[i], wd_t[i], f3_t[i], er, ee);
            n_checks++;
            if (!ok || rd !== exp_rd[i] || e !== exp_er[i] || lat != 3) begin
                n_fail++;
                $display("FAIL directed_%0d: ok=%0d rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=3",
                         i, ok, rd, e, lat, exp_rd[i], exp_er[i]);
            end
        end
        do_req(1'b0, 32'h10, 32'd0, F3_LW, 0, rd, e, lat, ok);
        n_checks++;
        if (!ok || rd !== 32'hDEAD7FEF || e !== 1'b0) begin
            n_fail++; $display("FAIL misaligned_sw_no_write: rdata=%h err=%b required DEAD7FEF/0", rd, e);
        end
        do_req(1'b0, 32'h1000, 32'd0, F3_LW, 0, rd, e, lat, ok);
        n_checks++;
        if (!ok || rd !== 32'd0 || e !== 1'b1 || lat != 3) begin
            n_fail++; $display("FAIL out_of_range: rdata=%h err=%b lat=%0d required 0/1/3", rd, e, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp1, exp2; logic ee; int guard;
        model_op(0, 1'b0, 32'h10, 32'd0, F3_LW, exp1, ee);
        model_op(0, 1'b0, 32'h20, 32'd0, F3_LW, exp2, ee);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_funct3 = F3_LW; resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h20;
        guard = 0;
        while (!resp_valid_s && guard < 50) begin @(negedge clk); guard++; end
        n_checks++;
        if (resp_valid_s !== 1'b1 || resp_rdata_s !== exp1) begin
            n_fail++; $display("FAIL bp_first: valid=%b rdata=%h required 1/%h", resp_valid_s, resp_rdata_s, exp1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid_s !== 1'b1 || resp_rdata_s !== exp1 || req_ready_s !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d: valid=%b rdata=%h ready=%b required 1/%h/0",
                                   i, resp_valid_s, resp_rdata_s, req_ready_s, exp1);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_checks++;
        if (resp_valid_s !== 1'b0 || req_ready_s !== 1'b1) begin
            n_fail++; $display("FAIL bp_no_same_cycle_accept: valid=%b ready=%b required 0/1", resp_valid_s, req_ready_s);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!resp_valid_s && guard < 50) begin @(negedge clk); guard++; end
        n_checks++;
        if (resp_valid_s !== 1'b1 || resp_rdata_s !== exp2 || resp_err_s !== 1'b0) begin
            n_fail++; $display("FAIL bp_second: valid=%b rdata=%h required 1/%h", resp_valid_s, resp_rdata_s, exp2);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, er; logic e, ee; int lat; bit ok; bit seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_funct3 = F3_SW;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (req_ready_s !== 1'b1 || resp_valid_s !== 1'b0 || resp_rdata_s !== 32'd0 || resp_err_s !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_state: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
                               req_ready_s, resp_valid_s, resp_rdata_s, resp_err_s);
        end
        seen = 1'b0;
        repeat (4) begin @(negedge clk); if (resp_valid_s !== 1'b0) seen = 1'b1; end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL rst_mid_no_resp: resp_valid seen=1 required 0");
        end
        do_req(1'b0, 32'h20, 32'd0, F3_LW, 0, rd, e, lat, ok);
        model_op(0, 1'b0, 32'h20, 32'd0, F3_LW, er, ee);
        n_checks++;
        if (!ok || rd !== er || e !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_write: rdata=%h err=%b required %h/0", rd, e, er);
        end
    endtask

    task automatic test_random(input int n);
        logic [31:0] rd, er, a, w; logic e, ee, we; logic [2:0] f3; int lat, r; bit ok;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 255));
            else if (r == 1) a = 32'hFFC + 32'($urandom_range(0, 3));
            else             a = 32'($urandom_range(0, 127));
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            w  = $urandom;
            do_req(we, a, w, f3, $urandom_range(0, 2), rd, e, lat, ok);
            model_op(0, we, a, w, f3, er, ee);
            n_checks++;
            if (!ok || rd !== er || e !== ee || lat != 3) begin
                n_fail++;
                $display("FAIL random_%0d: we=%b f3=%0d addr=%h ok=%0d rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=3",
                         i, we, f3, a, ok, rd, e, lat, er, ee);
            end
        end
    endtask

    task automatic test_back_to_back_w0();
        logic [31:0] er; logic ee; logic [31:0] q[$]; logic [31:0] exp_v;
        int last_acc, nacc;
        @(negedge clk);
        sel = 1'b1;
        test_preload(1, 2);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_funct3 = F3_LW; resp_ready = 1'b1;
        last_acc = -10; nacc = 0;
        for (int c = 0; c < 16; c++) begin
            if (resp_valid_s) begin
                exp_v = (q.size() > 0) ? q.pop_front() : 32'hBAD0BAD0;
                n_checks++;
                if (c != last_acc + 1 || resp_rdata_s !== exp_v || resp_err_s !== 1'b0) begin
                    n_fail++; $display("FAIL w0_resp_c%0d: rdata=%h err=%b acc_at=%0d required rdata=%h err=0 acc_at=%0d",
                                       c, resp_rdata_s, resp_err_s, last_acc, exp_v, c - 1);
                end
            end
            if (req_ready_s) begin
                if (nacc > 0) begin
                    n_checks++;
                    if (c != last_acc + 2) begin
                        n_fail++; $display("FAIL w0_accept_spacing: cycle=%0d prev=%0d required spacing 2", c, last_acc);
                    end
                end
                model_op(1, 1'b0, req_addr, 32'd0, F3_LW, er, ee);
                q.push_back(er);
                last_acc = c;
                nacc++;
            end else begin
                req_addr = (req_addr == 32'h0) ? 32'h4 : 32'h0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        n_checks++;
        if (nacc != 8) begin
            n_fail++; $display("FAIL w0_accept_count: accepts=%0d required 8", nacc);
        end
        @(negedge clk);
        resp_ready = 1'b0;
        @(negedge clk);
        sel = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_preload(0, 32);
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random(150);
        test_back_to_back_w0();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
